// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer.
//   pc_op_t    : 3-bit sequencing opcode; codes 5..7 are unassigned and
//                execute as OP_INC.
//   pc_state_t : sequencer FSM states.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_BR_REL = 3'd1,
    OP_BR_ABS = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } pc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  // Width of a counter able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle of the program-counter sequencer.
//   master : drives start/start_address/stall/halt/op/taken/target,
//            observes prog_ctr/done/stk_depth/ovf/unf.
//   slave  : the sequencer side (directions reversed).
// op is carried as raw 3 bits so unassigned codes can reach the sequencer.
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int SD = 4
);
  import pc_pkg::*;

  localparam int SW = cnt_width(SD);

  logic          start;
  logic [D-1:0]  start_address;
  logic          stall;
  logic          halt;
  logic [2:0]    op;
  logic          taken;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          done;
  logic [SW-1:0] stk_depth;
  logic          ovf;
  logic          unf;

  modport master (
    output start, start_address, stall, halt, op, taken, target,
    input  prog_ctr, done, stk_depth, ovf, unf
  );

  modport slave (
    input  start, start_address, stall, halt, op, taken, target,
    output prog_ctr, done, stk_depth, ovf, unf
  );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the sequencer.
// Ports:
//   clk, reset         : clock, async active-high reset (clears depth only)
//   clear              : synchronous empty, takes priority over push/pop
//   push, push_data    : write push_data on top (ignored when full)
//   pop                : discard top entry (ignored when empty)
//   data               : current top entry (valid when !empty)
//   depth, full, empty : occupancy status
// The caller never asserts push and pop together.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int D  = 12,
  parameter int SD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [D-1:0]           push_data,
  output logic [D-1:0]           data,
  output logic [cnt_width(SD)-1:0] depth,
  output logic                   full,
  output logic                   empty
);

  localparam int DW = cnt_width(SD);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  logic [D-1:0]  mem [SD];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign depth_m1 = depth_q - DW'(1);
  assign wr_idx   = depth_q[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];

  assign full  = (depth_q == DW'(SD));
  assign empty = (depth_q == '0);
  assign depth = depth_q;
  assign data  = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else if (clear) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_m1;
    end
  end

  // Entry storage carries no reset; only depth qualifies validity.
  always_ff @(posedge clk) begin
    if (!clear && push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch, call/return and halt control.
// Ports:
//   clk   : system clock, rising edge
//   reset : async active-high reset
//   bus   : pc_sequencer_if.slave (commands in, prog_ctr/status out)
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | after reset; ignores op/halt/stall, waits for start
// ST_RUN  | executes one op per unstalled cycle
// ST_HALT | frozen, done=1; only start or reset leaves it
//
// Cycle priority: reset > start > stall > halt > op.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D  = 12,
  parameter int SD = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  pc_state_t    state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  logic         stk_clear, stk_push, stk_pop;
  logic [D-1:0] stk_data;
  logic         stk_full, stk_empty;
  logic [D-1:0] pc_inc;

  assign pc_inc = pc_q + D'(1);

  pc_ret_stack #(.D(D), .SD(SD)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .data      (stk_data),
    .depth     (bus.stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;

    if (bus.start) begin
      state_d   = ST_RUN;
      pc_d      = bus.start_address;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      stk_clear = 1'b1;
    end else if (state_q == ST_RUN && !bus.stall) begin
      if (bus.halt) begin
        state_d = ST_HALT;
      end else begin
        case (bus.op)
          OP_BR_REL: pc_d = bus.taken ? (pc_q + bus.target) : pc_inc;
          OP_BR_ABS: pc_d = bus.taken ? bus.target : pc_inc;
          OP_CALL: begin
            // The jump happens even when the return address cannot be saved.
            pc_d = bus.target;
            if (stk_full) ovf_d = 1'b1;
            else          stk_push = 1'b1;
          end
          OP_RET: begin
            if (stk_empty) begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end else begin
              pc_d    = stk_data;
              stk_pop = 1'b1;
            end
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.done     = (state_q == ST_HALT);
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int D  = 12;
  localparam int SD = 4;
  localparam int MOD = 1 << D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.D(D), .SD(SD)) bus ();

  pc_sequencer #(.D(D), .SD(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic check_all(input string tag, input int e_pc, input int e_dep,
                           input int e_ovf, input int e_unf, input int e_done);
    check({tag, " pc"},    int'(bus.prog_ctr),  e_pc);
    check({tag, " depth"}, int'(bus.stk_depth), e_dep);
    check({tag, " ovf"},   int'(bus.ovf),       e_ovf);
    check({tag, " unf"},   int'(bus.unf),       e_unf);
    check({tag, " done"},  int'(bus.done),      e_done);
  endtask

  task automatic drive(input bit st, input int sa, input bit sl, input bit h,
                       input int op, input bit tk, input int tgt);
    bus.start         = st;
    bus.start_address = D'(sa);
    bus.stall         = sl;
    bus.halt          = h;
    bus.op            = 3'(op);
    bus.taken         = tk;
    bus.target        = D'(tgt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st; int sa; bit sl; bit h; int op; bit tk; int tgt;
    int e_pc; int e_dep; int e_ovf; int e_unf; int e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit st, input int sa, input bit sl, input bit h,
                     input int op, input bit tk, input int tgt,
                     input int e_pc, input int e_dep, input int e_ovf,
                     input int e_unf, input int e_done);
    vec_t v;
    v.st = st; v.sa = sa; v.sl = sl; v.h = h; v.op = op; v.tk = tk; v.tgt = tgt;
    v.e_pc = e_pc; v.e_dep = e_dep; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 halted
  int m_mode;
  int m_pc;
  int m_stk[$];
  int m_ovf, m_unf;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input bit st, input int sa, input bit sl, input bit h,
                            input int op, input bit tk, input int tgt);
    if (st) begin
      m_mode = 1; m_pc = sa % MOD; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_mode == 1 && !sl) begin
      if (h) m_mode = 2;
      else if (op == 1) m_pc = tk ? (m_pc + tgt) % MOD : (m_pc + 1) % MOD;
      else if (op == 2) m_pc = tk ? tgt : (m_pc + 1) % MOD;
      else if (op == 3) begin
        if (m_stk.size() == SD) m_ovf = 1;
        else m_stk.push_back((m_pc + 1) % MOD);
        m_pc = tgt;
      end else if (op == 4) begin
        if (m_stk.size() == 0) begin
          m_pc = (m_pc + 1) % MOD; m_unf = 1;
        end else m_pc = m_stk.pop_back();
      end else m_pc = (m_pc + 1) % MOD;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, OP_INC, 0, 0);

    // Reset state (async: checked before any clock edge)
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // IDLE ignores op/halt
    add(0,'h000,0,1,OP_BR_ABS,1,'h777, 'h000,0,0,0,0);
    add(0,'h000,0,0,OP_RET,   0,'h000, 'h000,0,0,0,0);
    // start + 3 INC
    add(1,'h010,0,0,OP_INC,0,0, 'h010,0,0,0,0);
    add(0,0,0,0,OP_INC,0,0,     'h011,0,0,0,0);
    add(0,0,0,0,OP_INC,0,0,     'h012,0,0,0,0);
    add(0,0,0,0,OP_INC,0,0,     'h013,0,0,0,0);
    // branches
    add(1,'h020,0,0,OP_INC,0,0,        'h020,0,0,0,0);
    add(0,0,0,0,OP_BR_REL,1,'hFFE,     'h01E,0,0,0,0);
    add(0,0,0,0,OP_BR_ABS,0,'h555,     'h01F,0,0,0,0);
    add(0,0,0,0,OP_BR_REL,0,'h100,     'h020,0,0,0,0);
    add(0,0,0,0,OP_BR_ABS,1,'h345,     'h345,0,0,0,0);
    // wrap
    add(1,'hFFF,0,0,OP_INC,0,0,        'hFFF,0,0,0,0);
    add(0,0,0,0,OP_INC,0,0,            'h000,0,0,0,0);
    add(1,'hFFE,0,0,OP_INC,0,0,        'hFFE,0,0,0,0);
    add(0,0,0,0,OP_BR_REL,1,'h005,     'h003,0,0,0,0);
    // call/return
    add(1,'h100,0,0,OP_INC,0,0,        'h100,0,0,0,0);
    add(0,0,0,0,OP_CALL,0,'h200,       'h200,1,0,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h101,0,0,0,0);
    // stack limits
    add(1,'h300,0,0,OP_INC,0,0,        'h300,0,0,0,0);
    add(0,0,0,0,OP_CALL,1,'h400,       'h400,1,0,0,0);
    add(0,0,0,0,OP_CALL,1,'h500,       'h500,2,0,0,0);
    add(0,0,0,0,OP_CALL,1,'h600,       'h600,3,0,0,0);
    add(0,0,0,0,OP_CALL,1,'h700,       'h700,4,0,0,0);
    add(0,0,0,0,OP_CALL,1,'h800,       'h800,4,1,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h601,3,1,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h501,2,1,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h401,1,1,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h301,0,1,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h302,0,1,1,0);
    add(0,0,1,0,OP_CALL,1,'h999,       'h302,0,1,1,0);
    // halt, stall, restart from HALT
    add(1,'h050,0,0,OP_INC,0,0,        'h050,0,0,0,0);
    add(0,0,0,1,OP_BR_ABS,1,'h0AA,     'h050,0,0,0,1);
    add(0,0,0,0,OP_INC,0,0,            'h050,0,0,0,1);
    add(1,'h060,0,1,OP_INC,0,0,        'h060,0,0,0,0);
    add(0,0,1,1,OP_INC,0,0,            'h060,0,0,0,0);
    add(0,0,0,0,OP_INC,0,0,            'h061,0,0,0,0);
    // unassigned opcodes behave as INC
    add(0,0,0,0,5,1,'h777,             'h062,0,0,0,0);
    add(0,0,0,0,6,1,'h777,             'h063,0,0,0,0);
    add(0,0,0,0,7,1,'h777,             'h064,0,0,0,0);
    add(1,'h0AB,1,0,OP_INC,0,0,        'h0AB,0,0,0,0);
    // stall holds a CALL
    add(1,'h070,0,0,OP_INC,0,0,        'h070,0,0,0,0);
    add(0,0,1,0,OP_CALL,0,'h123,       'h070,0,0,0,0);
    add(0,0,0,0,OP_CALL,0,'h123,       'h123,1,0,0,0);
    add(0,0,0,0,OP_RET,0,0,            'h071,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sa, vecs[i].sl, vecs[i].h,
            vecs[i].op, vecs[i].tk, vecs[i].tgt);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_dep,
                vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_done);
    end

    // Async reset between edges while running at pc=0x123, depth 2
    drive(1, 'h000, 0, 0, OP_INC, 0, 0);       tick();
    drive(0, 0, 0, 0, OP_CALL, 0, 'h050);      tick();
    drive(0, 0, 0, 0, OP_CALL, 0, 'h123);      tick();
    check_all("pre_rst", 'h123, 2, 0, 0, 0);
    drive(0, 0, 0, 0, OP_INC, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    check_all("idle_after_rst", 0, 0, 0, 0, 0);

    // Randomized run against the reference model
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      bit st, sl, h, tk;
      int sa, op, tgt, r;
      st  = (n == 0) || ($urandom_range(0, 99) < 2);
      sl  = ($urandom_range(0, 99) < 15);
      h   = ($urandom_range(0, 99) < 3);
      tk  = $urandom_range(0, 1);
      sa  = $urandom_range(0, MOD - 1);
      tgt = $urandom_range(0, MOD - 1);
      r   = $urandom_range(0, 9);
      op  = (r < 3) ? int'(OP_CALL) : (r < 6) ? int'(OP_RET) : $urandom_range(0, 7);
      drive(st, sa, sl, h, op, tk, tgt);
      model_step(st, sa, sl, h, op, tk, tgt);
      tick();
      check_all($sformatf("rnd%0d", n), m_pc, m_stk.size(), m_ovf, m_unf,
                (m_mode == 2) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
